// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control sequencer for the single-issue RV32I core.
//
// Each instruction moves through FETCH -> DECODE -> EXEC -> [MEM] -> WB. This
// block owns the shared memory port handshake and the datapath write strobes.
// Apart from the state transition, the only strobes that depend on mem_ack are
// the ones that must land with the accepted access: ir_we in FETCH, and pc_we
// plus the retire increment on a store completing in MEM.
//
// Ports:
//   clk, rst_n          core clock, asynchronous active-low reset
//   run                 level; allows new instructions to start
//   opcode, controls    IR[6:0] and decoder bus (valid from DECODE onward)
//   branch_taken        ALU compare result, used in WB
//   mem_ack             memory accepted/completed the current request
//   mem_req, mem_we,    memory request, store qualifier, address select
//   mem_addr_sel          (0 = PC, 1 = ALU result)
//   ir_we, op_we,       datapath latch strobes
//   alu_we, rf_we
//   pc_we, pc_sel       PC update and source (0 = PC+4, 1 = target)
//   state               current state encoding
//   trap, trap_cause    sticky fault flag and cause (01 illegal, 10 timeout)
//   instret             retired instruction count (wraps)
module core_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic [9:0]       controls,
    input  logic             branch_taken,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_we,
    output logic             op_we,
    output logic             alu_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic [2:0]       state,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    localparam int unsigned TmoW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StTrap   = 3'd7
    } state_e;

    state_e            state_q, state_d;
    logic [9:0]        ctl_q, ctl_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic [1:0]        cause_q, cause_d;
    logic [CNT_W-1:0]  instret_q, instret_d;

    logic [TmoW:0]     tmo_inc;
    logic              tmo_hit;
    logic              grp_ok;
    logic              illegal;

    // Only branch, MemRead, MemWrite, RegWrite and unconditional steer the sequence.
    logic unused_ctl_bits;
    assign unused_ctl_bits = ^{ctl_q[9], ctl_q[6:3]};

    // Count of unacknowledged request cycles including the current one.
    assign tmo_inc = {1'b0, tmo_q} + {{TmoW{1'b0}}, 1'b1};
    assign tmo_hit = (tmo_inc == (TmoW + 1)'(MEM_TIMEOUT));

    always_comb begin
        grp_ok = 1'b0;
        case (opcode[6:4])
            3'b000, 3'b001, 3'b010, 3'b011: grp_ok = 1'b1;
            3'b110:                         grp_ok = (opcode[3:2] != 2'b10);
            default:                        grp_ok = 1'b0;
        endcase
        illegal = (opcode[1:0] != 2'b11) || !grp_ok;
    end

    always_comb begin
        state_d      = state_q;
        ctl_d        = ctl_q;
        tmo_d        = '0;
        cause_d      = cause_q;
        instret_d    = instret_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        op_we        = 1'b0;
        alu_we       = 1'b0;
        rf_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 1'b0;

        case (state_q)
            StIdle: begin
                if (run) state_d = StFetch;
            end
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we   = 1'b1;
                    state_d = StDecode;
                end else if (tmo_hit) begin
                    state_d = StTrap;
                    cause_d = 2'b10;
                end else begin
                    tmo_d = tmo_inc[TmoW-1:0];
                end
            end
            StDecode: begin
                op_we = 1'b1;
                ctl_d = controls;
                if (illegal) begin
                    state_d = StTrap;
                    cause_d = 2'b01;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                alu_we  = 1'b1;
                state_d = (ctl_q[1] || ctl_q[2]) ? StMem : StWb;
            end
            StMem: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = ctl_q[2];
                if (mem_ack) begin
                    if (ctl_q[2]) begin
                        // Stores retire here; there is no WB visit.
                        pc_we     = 1'b1;
                        instret_d = instret_q + CNT_W'(1);
                        state_d   = run ? StFetch : StIdle;
                    end else begin
                        state_d = StWb;
                    end
                end else if (tmo_hit) begin
                    state_d = StTrap;
                    cause_d = 2'b10;
                end else begin
                    tmo_d = tmo_inc[TmoW-1:0];
                end
            end
            StWb: begin
                rf_we     = ctl_q[7];
                pc_we     = 1'b1;
                pc_sel    = ctl_q[0] & (ctl_q[8] | branch_taken);
                instret_d = instret_q + CNT_W'(1);
                state_d   = run ? StFetch : StIdle;
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ctl_q     <= '0;
            tmo_q     <= '0;
            cause_q   <= 2'b00;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            ctl_q     <= ctl_d;
            tmo_q     <= tmo_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
        end
    end

    assign state      = state_q;
    assign trap       = (state_q == StTrap);
    assign trap_cause = cause_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: the stimulus process pushes the
// hand-computed expected state/strobe/status vector for every cycle it drives,
// and a separate monitor pops and compares on the falling clock edge.
module tb_core_sequencer;

    localparam int unsigned MemTimeout = 4;
    localparam int unsigned CntW       = 3;

    // Strobe vectors: {mem_req, mem_we, mem_addr_sel, ir_we, op_we, alu_we, rf_we, pc_we, pc_sel}
    localparam logic [8:0] SNone  = 9'h000;
    localparam logic [8:0] SFWait = 9'h100;
    localparam logic [8:0] SFAck  = 9'h120;
    localparam logic [8:0] SDec   = 9'h010;
    localparam logic [8:0] SExe   = 9'h008;
    localparam logic [8:0] SWbRf  = 9'h006;
    localparam logic [8:0] SWbPc  = 9'h002;
    localparam logic [8:0] SMLd   = 9'h140;
    localparam logic [8:0] SMStA  = 9'h1C2;

    logic            clk;
    logic            rst_n;
    logic            run;
    logic [6:0]      opcode;
    logic [9:0]      controls;
    logic            branch_taken;
    logic            mem_ack;
    logic            mem_req;
    logic            mem_we;
    logic            mem_addr_sel;
    logic            ir_we;
    logic            op_we;
    logic            alu_we;
    logic            rf_we;
    logic            pc_we;
    logic            pc_sel;
    logic [2:0]      state;
    logic            trap;
    logic [1:0]      trap_cause;
    logic [CntW-1:0] instret;

    core_sequencer #(
        .MEM_TIMEOUT(MemTimeout),
        .CNT_W      (CntW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .opcode      (opcode),
        .controls    (controls),
        .branch_taken(branch_taken),
        .mem_ack     (mem_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr_sel(mem_addr_sel),
        .ir_we       (ir_we),
        .op_we       (op_we),
        .alu_we      (alu_we),
        .rf_we       (rf_we),
        .pc_we       (pc_we),
        .pc_sel      (pc_sel),
        .state       (state),
        .trap        (trap),
        .trap_cause  (trap_cause),
        .instret     (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [17:0] v;
    } exp_t;

    exp_t            exp_q[$];
    exp_t            mon_e;
    logic [17:0]     act;
    int unsigned     n_vec = 0;
    int unsigned     n_bad = 0;
    logic [1:0]      exp_cause;
    logic [CntW-1:0] exp_ret;
    string           tag;

    // Monitor: one expected vector per driven cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            act = {state, mem_req, mem_we, mem_addr_sel, ir_we, op_we, alu_we, rf_we,
                   pc_we, pc_sel, trap, trap_cause, instret};
            n_vec++;
            if (act !== mon_e.v) begin
                n_bad++;
                $display("FAIL %s @%0t: got state=%0d strobes=%b trap=%b cause=%b instret=%0d, required state=%0d strobes=%b trap=%b cause=%b instret=%0d",
                         mon_e.name, $time, act[17:15], act[14:6], act[5], act[4:3], act[2:0],
                         mon_e.v[17:15], mon_e.v[14:6], mon_e.v[5], mon_e.v[4:3], mon_e.v[2:0]);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected during it.
    task automatic cyc(input logic r, input logic ack, input logic bt,
                       input logic [2:0] st, input logic [8:0] stb);
        exp_t e;
        run          = r;
        mem_ack      = ack;
        branch_taken = bt;
        e.name = tag;
        e.v    = {st, stb, (st == 3'd7), exp_cause, exp_ret};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (stb[1]) exp_ret = exp_ret + CntW'(1);
    endtask

    // Zero-wait instruction body from FETCH through EXEC.
    task automatic fde(input logic r_exec);
        cyc(1'b1, 1'b1, 1'b0, 3'd1, SFAck);
        cyc(1'b1, 1'b1, 1'b0, 3'd2, SDec);
        cyc(r_exec, 1'b1, 1'b0, 3'd3, SExe);
    endtask

    initial begin
        rst_n        = 1'b0;
        run          = 1'b0;
        mem_ack      = 1'b0;
        branch_taken = 1'b0;
        opcode       = 7'd0;
        controls     = 10'd0;
        exp_cause    = 2'b00;
        exp_ret      = '0;
        @(posedge clk);
        #1;

        tag = "reset";
        cyc(1'b0, 1'b0, 1'b0, 3'd0, SNone);
        cyc(1'b1, 1'b1, 1'b0, 3'd0, SNone);
        rst_n = 1'b1;
        tag = "idle_hold";
        cyc(1'b0, 1'b1, 1'b0, 3'd0, SNone);

        tag = "add";
        opcode = 7'b0110011; controls = 10'h080;
        cyc(1'b1, 1'b1, 1'b0, 3'd0, SNone);
        fde(1'b1);
        cyc(1'b1, 1'b1, 1'b0, 3'd5, SWbRf);

        tag = "load_wait2";
        opcode = 7'b0000011; controls = 10'h082;
        cyc(1'b1, 1'b0, 1'b0, 3'd1, SFWait);
        cyc(1'b1, 1'b0, 1'b0, 3'd1, SFWait);
        cyc(1'b1, 1'b1, 1'b0, 3'd1, SFAck);
        cyc(1'b1, 1'b1, 1'b0, 3'd2, SDec);
        cyc(1'b1, 1'b1, 1'b0, 3'd3, SExe);
        cyc(1'b1, 1'b0, 1'b0, 3'd4, SMLd);
        cyc(1'b1, 1'b0, 1'b0, 3'd4, SMLd);
        cyc(1'b1, 1'b1, 1'b0, 3'd4, SMLd);
        cyc(1'b1, 1'b1, 1'b0, 3'd5, SWbRf);

        tag = "store";
        opcode = 7'b0100011; controls = 10'h004;
        fde(1'b1);
        cyc(1'b1, 1'b1, 1'b0, 3'd4, SMStA);

        tag = "beq_not_taken";
        opcode = 7'b1100011; controls = 10'h001;
        fde(1'b1);
        cyc(1'b1, 1'b1, 1'b0, 3'd5, SWbPc);

        tag = "beq_taken";
        fde(1'b1);
        cyc(1'b1, 1'b1, 1'b1, 3'd5, SWbPc | 9'h001);

        tag = "jal";
        opcode = 7'b1101111; controls = 10'h181;
        fde(1'b1);
        cyc(1'b1, 1'b1, 1'b0, 3'd5, SWbRf | 9'h001);

        // Three more ALU ops take the 3-bit retire count past its wrap point.
        tag = "add_wrap";
        opcode = 7'b0110011; controls = 10'h080;
        for (int i = 0; i < 3; i++) begin
            fde(1'b1);
            cyc(1'b1, 1'b1, 1'b0, 3'd5, SWbRf);
        end

        tag = "ack_on_4th";
        cyc(1'b1, 1'b0, 1'b0, 3'd1, SFWait);
        cyc(1'b1, 1'b0, 1'b0, 3'd1, SFWait);
        cyc(1'b1, 1'b0, 1'b0, 3'd1, SFWait);
        cyc(1'b1, 1'b1, 1'b0, 3'd1, SFAck);
        cyc(1'b1, 1'b1, 1'b0, 3'd2, SDec);
        tag = "run_drop";
        cyc(1'b0, 1'b1, 1'b0, 3'd3, SExe);
        cyc(1'b0, 1'b1, 1'b0, 3'd5, SWbRf);
        cyc(1'b0, 1'b1, 1'b0, 3'd0, SNone);
        cyc(1'b0, 1'b1, 1'b0, 3'd0, SNone);

        tag = "fetch_timeout";
        cyc(1'b1, 1'b0, 1'b0, 3'd0, SNone);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 3'd1, SFWait);
        exp_cause = 2'b10;
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 3'd7, SNone);

        rst_n = 1'b0; exp_cause = 2'b00; exp_ret = '0;
        tag = "reset_clears_trap";
        cyc(1'b1, 1'b0, 1'b0, 3'd0, SNone);
        rst_n = 1'b1;

        tag = "illegal";
        opcode = 7'b1111111; controls = 10'h000;
        cyc(1'b1, 1'b1, 1'b0, 3'd0, SNone);
        cyc(1'b1, 1'b1, 1'b0, 3'd1, SFAck);
        cyc(1'b1, 1'b1, 1'b0, 3'd2, SDec);
        exp_cause = 2'b01;
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b0, 3'd7, SNone);

        rst_n = 1'b0; exp_cause = 2'b00;
        tag = "reset_after_illegal";
        cyc(1'b1, 1'b0, 1'b0, 3'd0, SNone);
        rst_n = 1'b1;

        // Reset lands mid-cycle while a fetch is outstanding.
        tag = "async_reset";
        opcode = 7'b0110011; controls = 10'h080;
        cyc(1'b1, 1'b0, 1'b0, 3'd0, SNone);
        cyc(1'b1, 1'b0, 1'b0, 3'd1, SFWait);
        cyc(1'b1, 1'b0, 1'b0, 3'd1, SFWait);
        rst_n = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 3'd0, SNone);
        rst_n = 1'b1;
        // Timeout count must restart from zero after the reset.
        tag = "tmo_cleared";
        cyc(1'b1, 1'b0, 1'b0, 3'd0, SNone);
        cyc(1'b1, 1'b0, 1'b0, 3'd1, SFWait);
        cyc(1'b1, 1'b0, 1'b0, 3'd1, SFWait);
        cyc(1'b1, 1'b0, 1'b0, 3'd1, SFWait);
        cyc(1'b1, 1'b1, 1'b0, 3'd1, SFAck);
        cyc(1'b0, 1'b1, 1'b0, 3'd2, SDec);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d unchecked vectors, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
